// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg: shared slice width and sequencer state encoding
package nibble_serial_adder_ctrl_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// add4_slice: combinational 4-bit adder slice with carry in/out
module add4_slice
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] Sum,
  output logic               Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{SLICE_W{1'b0}}, Cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide add sequenced one nibble per cycle through a shared slice
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES,
  localparam int IW      = NIBBLES > 1 ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         busy
);
  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_ss;
  logic               w_co;
  logic               w_last;

  assign w_sa      = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_sb      = r_b[SLICE_W*r_idx +: SLICE_W];
  assign w_last    = r_idx == IW'(NIBBLES - 1);
  assign in_ready  = r_state == IDLE && !rst;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign Sum       = r_sum;
  assign Cout      = r_cout;

  add4_slice u_slice (
    .A   (w_sa),
    .B   (w_sb),
    .Cin (r_carry),
    .Sum (w_ss),
    .Cout(w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= A;
        r_b     <= B;
        r_carry <= Cin;
        r_idx   <= '0;
        r_sum   <= '0;
        r_state <= RUN;
      end
    end else if (r_state == RUN) begin
      r_sum[SLICE_W*r_idx +: SLICE_W] <= w_ss;
      r_carry <= w_co;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout  <= w_co;
        r_state <= DONE;
      end
    end else if (out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: randomized and directed checks against an arithmetic reference
module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, cout, busy, cin = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, cout1, busy1, cin1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  int          checks = 0, passed = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b), .Cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Cout(cout), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .A(a1), .B(b1), .Cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .Sum(sum1), .Cout(cout1), .busy(busy1)
  );

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                        output logic [15:0] so, output logic co, output int lat, output int busy_bad);
    int n;
    @(negedge clk);
    a = ai; b = bi; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0; busy_bad = 0;
    while (!out_valid && lat < 50) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_bad++;
    so = sum; co = cout;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, sum, cout, in_ready1, busy1} !== 23'd0)
      $display("FAIL reset_state: ready=%b valid=%b busy=%b sum=%h cout=%b ready1=%b busy1=%b, want all 0",
               in_ready, out_valid, busy, sum, cout, in_ready1, busy1);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1)
      $display("FAIL reset_release: in_ready=%b in_ready1=%b, want 1 1", in_ready, in_ready1);
    else passed++;
  endtask

  task automatic test_directed_and_random();
    logic [15:0] va, vb, s;
    logic        vc, c;
    logic [16:0] e;
    int          lat, bb;
    for (int i = 0; i < 15; i++) begin
      case (i)
        0: begin va = 16'h1234; vb = 16'h4321; vc = 1'b0; end
        1: begin va = 16'hFFFF; vb = 16'h0000; vc = 1'b1; end
        2: begin va = 16'hA5A5; vb = 16'h5A5A; vc = 1'b0; end
        3: begin va = 16'hFFFF; vb = 16'hFFFF; vc = 1'b1; end
        default: begin va = 16'($urandom); vb = 16'($urandom); vc = 1'($urandom); end
      endcase
      e = ref_add(va, vb, vc);
      run_op(va, vb, vc, s, c, lat, bb);
      checks++;
      if ({c, s} !== e) $display("FAIL add_%0d: %h+%h+%b got %b_%h, want %b_%h", i, va, vb, vc, c, s, e[16], e[15:0]);
      else passed++;
      checks++;
      if (lat !== 4 || bb !== 0) $display("FAIL latency_busy_%0d: lat=%0d busy_low=%0d, want 4 0", i, lat, bb);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] e;
    int          n;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    e = ref_add(16'h1234, 16'h1111, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({cout, sum} !== e || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL hold_%0d: %b_%h valid=%b in_ready=%b, want %b_%h 1 0", i, cout, sum, out_valid, in_ready, e[16], e[15:0]);
      else passed++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL next_accept: busy=%b, want 1", busy);
    else passed++;
    e = ref_add(16'h0F0F, 16'h0101, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if ({cout, sum} !== e) $display("FAIL bp_next_result: %b_%h, want %b_%h", cout, sum, e[16], e[15:0]);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] s;
    logic        c;
    int          lat, bb, n;
    @(negedge clk);
    a = 16'h8888; b = 16'h8888; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sum !== 16'h0010 || busy !== 1'b1) $display("FAIL partial: sum=%h busy=%b, want 0010 1", sum, busy);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sum, cout, out_valid, busy, in_ready} !== 20'd0)
      $display("FAIL mid_reset: sum=%h cout=%b valid=%b busy=%b ready=%b, want all 0", sum, cout, out_valid, busy, in_ready);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h0001, 16'h0002, 1'b1, s, c, lat, bb);
    checks++;
    if ({c, s} !== 17'h00004 || lat !== 4) $display("FAIL after_reset: %b_%h lat=%0d, want 0_0004 4", c, s, lat);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [16:0] expq[$];
    int          acc_t[$];
    int          got = 0, acc = 0, n = 0;
    logic        chg = 1'b0, drop = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    while (got < 3 && n < 100) begin
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) $display("FAIL b2b_extra: unexpected result %b_%h", cout, sum);
        else if ({cout, sum} !== expq[0]) $display("FAIL b2b_%0d: %b_%h, want %b_%h", got, cout, sum, expq[0][16], expq[0][15:0]);
        else passed++;
        if (expq.size() != 0) void'(expq.pop_front());
        got++;
      end
      if (in_ready && in_valid) begin
        expq.push_back(ref_add(a, b, cin));
        acc_t.push_back(cyc);
        acc++;
        chg = 1'b1;
        drop = acc == 3;
      end
      @(negedge clk);
      n++;
      if (drop) in_valid = 1'b0;
      if (chg) begin a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); chg = 1'b0; end
    end
    checks++;
    if (got !== 3 || acc_t.size() !== 3) $display("FAIL b2b_timeout: results=%0d accepts=%0d, want 3 3", got, acc_t.size());
    else passed++;
    for (int i = 1; i < acc_t.size(); i++) begin
      checks++;
      if (acc_t[i] - acc_t[i-1] !== 6) $display("FAIL b2b_spacing_%0d: %0d cycles, want 6", i, acc_t[i] - acc_t[i-1]);
      else passed++;
    end
  endtask

  task automatic test_n1();
    logic [3:0] va, vb;
    logic       vc;
    logic [4:0] e;
    int         lat, n;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin va = 4'h8; vb = 4'hD; vc = 1'b1; end
        1: begin va = 4'hA; vb = 4'h5; vc = 1'b1; end
        default: begin va = 4'($urandom); vb = 4'($urandom); vc = 1'($urandom); end
      endcase
      e = 5'(va) + 5'(vb) + 5'(vc);
      @(negedge clk);
      a1 = va; b1 = vb; cin1 = vc; in_valid1 = 1'b1;
      n = 0;
      while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if ({cout1, sum1} !== e || lat !== 1)
        $display("FAIL n1_%0d: %h+%h+%b got %b_%h lat=%0d, want %b_%h 1", i, va, vb, vc, cout1, sum1, lat, e[4], e[3:0]);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed_and_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_n1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
